// File: rtl/amds_uart_byte_rx_if.sv
// amds_uart_byte_rx_if: serial line, arm strobe and result bundle of the AMDS byte receiver
// master: drives din/start_rx and observes results (packet assembler or bench)
// slave : the receiver itself
interface amds_uart_byte_rx_if;
  logic       din;
  logic       start_rx;
  logic       is_byte_valid;
  logic       is_byte_corrupt;
  logic       is_rx_timeout;
  logic [7:0] dout;
  logic       busy;
  modport master (output din, start_rx, input is_byte_valid, is_byte_corrupt, is_rx_timeout, dout, busy);
  modport slave (input din, start_rx, output is_byte_valid, is_byte_corrupt, is_rx_timeout, dout, busy);
endinterface

// File: rtl/amds_uart_byte_rx.sv
// amds_uart_byte_rx: single-byte UART receiver (start, 8 data LSB-first, parity, stop) for one AMDS data line
// clk/rst_n : system clock, asynchronous active-low reset
// bus.din   : raw serial line (idle high, asynchronous); bus.start_rx arms for one byte
// bus.is_byte_valid/is_byte_corrupt/is_rx_timeout : one-cycle result pulses in the first IDLE cycle
// bus.dout  : last received byte, held until next result; bus.busy : state != IDLE
module amds_uart_byte_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int TIMEOUT_CLKS = 2000,
  parameter bit PARITY_ODD   = 1'b0
) (
  input logic clk,
  input logic rst_n,
  amds_uart_byte_rx_if.slave bus
);
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS);
  localparam logic [TMR_W-1:0] HALF_END = TMR_W'(CLKS_PER_BIT/2-1);
  localparam logic [TMR_W-1:0] BIT_END = TMR_W'(CLKS_PER_BIT-1);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TIMEOUT_CLKS-1);
  typedef enum logic [2:0] {IDLE, WAIT_START, START, DATA, PARITY, STOP} state_t;
  state_t r_state, w_state;
  logic r_din_m, r_din_s;
  logic [TMO_W-1:0] r_tmo, w_tmo;
  logic [TMR_W-1:0] r_tmr, w_tmr;
  logic [2:0] r_idx, w_idx;
  logic [7:0] r_shift, w_shift, r_dout, w_dout;
  logic r_par_err, w_par_err;
  logic r_valid, w_valid, r_corrupt, w_corrupt, r_timeout, w_timeout, r_busy;
  logic w_timed, w_end;
  // START waits half a bit to land on mid-bit; later states wait a full bit from there
  assign w_timed = r_state inside {START, DATA, PARITY, STOP};
  assign w_end = (r_state == START) ? (r_tmr == HALF_END) : (r_tmr == BIT_END);
  assign w_tmr = (w_timed && !w_end) ? r_tmr + 1'b1 : '0;
  always_comb begin
    w_state = r_state;
    w_tmo = r_tmo;
    w_idx = r_idx;
    w_shift = r_shift;
    w_dout = r_dout;
    w_par_err = r_par_err;
    w_valid = 1'b0;
    w_corrupt = 1'b0;
    w_timeout = 1'b0;
    // an arm strobe in any state (re)starts the wait and silently drops a frame in flight
    if (bus.start_rx) begin
      w_state = WAIT_START;
      w_tmo = '0;
    end else begin
      case (r_state)
        WAIT_START:
          if (!r_din_s) w_state = START;
          else if (r_tmo == TMO_END) begin
            w_state = IDLE;
            w_timeout = 1'b1;
          end else w_tmo = r_tmo + 1'b1;
        // a glitch returns to WAIT_START with the timeout budget already spent preserved
        START:
          if (w_end) begin
            w_idx = '0;
            w_state = r_din_s ? WAIT_START : DATA;
          end
        DATA:
          if (w_end) begin
            w_shift[r_idx] = r_din_s;
            w_idx = r_idx + 1'b1;
            w_state = (r_idx == 3'd7) ? PARITY : DATA;
          end
        PARITY:
          if (w_end) begin
            w_par_err = ((^r_shift) ^ r_din_s) != PARITY_ODD;
            w_state = STOP;
          end
        STOP:
          if (w_end) begin
            w_state = IDLE;
            w_dout = r_shift;
            w_corrupt = r_par_err | ~r_din_s;
            w_valid = ~(r_par_err | ~r_din_s);
          end
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din_m <= 1'b1;
      r_din_s <= 1'b1;
      r_state <= IDLE;
      r_tmo <= '0;
      r_tmr <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_dout <= '0;
      r_par_err <= 1'b0;
      r_valid <= 1'b0;
      r_corrupt <= 1'b0;
      r_timeout <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_din_m <= bus.din;
      r_din_s <= r_din_m;
      r_state <= w_state;
      r_tmo <= w_tmo;
      r_tmr <= w_tmr;
      r_idx <= w_idx;
      r_shift <= w_shift;
      r_dout <= w_dout;
      r_par_err <= w_par_err;
      r_valid <= w_valid;
      r_corrupt <= w_corrupt;
      r_timeout <= w_timeout;
      r_busy <= (w_state != IDLE);
    end
  end
  assign bus.is_byte_valid = r_valid;
  assign bus.is_byte_corrupt = r_corrupt;
  assign bus.is_rx_timeout = r_timeout;
  assign bus.dout = r_dout;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_amds_uart_byte_rx.sv
// tb_amds_uart_byte_rx: directed vectors and corner sequences for the AMDS byte receiver
module tb_amds_uart_byte_rx;
  localparam int CPB = 8;
  typedef struct {logic [7:0] data; logic par; logic stop; int kind;} vec_t;
  typedef struct {int kind; logic [7:0] d; int cyc; logic busy;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_start = 1'b0;
  logic chain = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int arm_cyc = 0;
  ev_t evq[$];
  vec_t vecs[7];
  amds_uart_byte_rx_if bus();
  amds_uart_byte_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.start_rx = tb_start | (chain & bus.is_byte_valid);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.is_byte_valid) evq.push_back(ev_t'{1, bus.dout, cyc, bus.busy});
    if (bus.is_byte_corrupt) evq.push_back(ev_t'{2, bus.dout, cyc, bus.busy});
    if (bus.is_rx_timeout) evq.push_back(ev_t'{3, bus.dout, cyc, bus.busy});
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic arm();
    tb_start = 1'b1;
    arm_cyc = cyc + 1;
    tick(1);
    tb_start = 1'b0;
  endtask
  task automatic send_bits(input logic [7:0] d, input logic p, input logic s, input int nb);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nb; i++) begin
      bus.din = f[i];
      tick(CPB);
    end
    bus.din = 1'b1;
  endtask
  task automatic wait_ev(input int lim, input string nm);
    for (int i = 0; i < lim && evq.size() == 0; i++) tick(1);
    chk({nm, "_seen"}, 32'(evq.size() > 0), 1);
    if (evq.size() == 0) evq.push_back(ev_t'{0, 8'hxx, 0, 1'bx});
  endtask
  task automatic chk_outs(input string nm);
    chk({nm, "_valid"}, 32'(bus.is_byte_valid), 0);
    chk({nm, "_corrupt"}, 32'(bus.is_byte_corrupt), 0);
    chk({nm, "_timeout"}, 32'(bus.is_rx_timeout), 0);
    chk({nm, "_dout"}, 32'(bus.dout), 0);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
  endtask
  initial begin
    vecs[0] = '{8'h91, 1'b1, 1'b1, 1};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 2};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 2};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 2};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 1};
    bus.din = 1'b1;
    tick(3);
    chk_outs("reset");
    rst_n = 1'b1;
    tick(3);
    for (int v = 0; v < 7; v++) begin
      evq.delete();
      arm();
      tick(2);
      send_bits(vecs[v].data, vecs[v].par, vecs[v].stop, 11);
      wait_ev(20, "vec");
      chk("vec_kind", 32'(evq[0].kind), 32'(vecs[v].kind));
      chk("vec_dout", 32'(evq[0].d), 32'(vecs[v].data));
      chk("vec_busy_at_pulse", 32'(evq[0].busy), 0);
      tick(20);
      chk("vec_pulse_count", 32'(evq.size()), 1);
    end
    evq.delete();
    arm();
    tick(2);
    send_bits(8'hC3, 1'b0, 1'b1, 4);
    tick(3);
    arm();
    tick(30);
    chk("abort_quiet", 32'(evq.size()), 0);
    chk("abort_busy", 32'(bus.busy), 1);
    send_bits(8'h5A, 1'b0, 1'b1, 11);
    wait_ev(20, "abort");
    chk("abort_kind", 32'(evq[0].kind), 1);
    chk("abort_dout", 32'(evq[0].d), 32'h5A);
    tick(20);
    chk("abort_count", 32'(evq.size()), 1);
    evq.delete();
    bus.din = 1'b0;
    tick(3);
    arm();
    wait_ev(150, "low");
    chk("low_kind", 32'(evq[0].kind), 2);
    chk("low_dout", 32'(evq[0].d), 0);
    bus.din = 1'b1;
    tick(5);
    evq.delete();
    arm();
    tick(100);
    chk("tmo_busy_waiting", 32'(bus.busy), 1);
    wait_ev(2100, "tmo");
    chk("tmo_kind", 32'(evq[0].kind), 3);
    chk("tmo_latency", 32'(evq[0].cyc - arm_cyc), 2000);
    chk("tmo_busy_at_pulse", 32'(evq[0].busy), 0);
    tick(5);
    chk("tmo_idle", 32'(bus.busy), 0);
    chk("tmo_count", 32'(evq.size()), 1);
    evq.delete();
    arm();
    tick(200);
    bus.din = 1'b0;
    tick(2);
    bus.din = 1'b1;
    wait_ev(2100, "glitch");
    chk("glitch_kind", 32'(evq[0].kind), 3);
    chk("glitch_latency_window", 32'((evq[0].cyc - arm_cyc) >= 2000 && (evq[0].cyc - arm_cyc) <= 2010), 1);
    tick(5);
    chk("glitch_count", 32'(evq.size()), 1);
    evq.delete();
    chain = 1'b1;
    arm();
    tick(2);
    send_bits(8'h90, 1'b0, 1'b1, 11);
    send_bits(8'h12, 1'b0, 1'b1, 11);
    send_bits(8'h34, 1'b1, 1'b1, 11);
    tick(5);
    chain = 1'b0;
    chk("b2b_count", 32'(evq.size()), 3);
    while (evq.size() < 3) evq.push_back(ev_t'{0, 8'hxx, 0, 1'bx});
    chk("b2b_kind0", 32'(evq[0].kind), 1);
    chk("b2b_dout0", 32'(evq[0].d), 32'h90);
    chk("b2b_kind1", 32'(evq[1].kind), 1);
    chk("b2b_dout1", 32'(evq[1].d), 32'h12);
    chk("b2b_kind2", 32'(evq[2].kind), 1);
    chk("b2b_dout2", 32'(evq[2].d), 32'h34);
    evq.delete();
    arm();
    tick(2);
    send_bits(8'h55, 1'b0, 1'b1, 5);
    tick(4);
    chk("midrst_busy_before", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #2;
    chk_outs("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("midrst_no_pulse", 32'(evq.size()), 0);
    arm();
    tick(2);
    send_bits(8'h55, 1'b0, 1'b1, 11);
    wait_ev(20, "after_rst");
    chk("after_rst_kind", 32'(evq[0].kind), 1);
    chk("after_rst_dout", 32'(evq[0].d), 32'h55);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
